// File: rtl/usb_fs_rx_phy_pkg.sv
// Shared encodings and constants for the full-speed USB receive front end.
package usb_rx_pkg;

    // Encoding matches {dm, dp}, so the raw pin pair maps straight onto it.
    typedef enum logic [1:0] {
        LS_SE0 = 2'd0,
        LS_J   = 2'd1,
        LS_K   = 2'd2,
        LS_SE1 = 2'd3
    } line_state_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_ABORT
    } rx_state_t;

    localparam int unsigned SYNC_MIN_ZEROS = 3;
    localparam int unsigned DRIBBLE_MAX    = 1;

    function automatic line_state_t decode_line(input logic dp, input logic dm);
        return line_state_t'({dm, dp});
    endfunction

endpackage

// File: rtl/usb_fs_rx_phy_dpll.sv
// Bit-timing recovery: free-running phase counter that re-aligns on every
// line transition and strobes once per bit near the middle of the bit cell.
module usb_rx_dpll #(
    parameter int unsigned OVERSAMPLE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic resync,
    output logic bit_strobe
);

    localparam int unsigned PW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    logic [PW-1:0] phase;

    always_ff @(posedge clk) begin
        if (rst || !en || resync) begin
            phase <= '0;
        end else if (phase == PW'(OVERSAMPLE - 1)) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    assign bit_strobe = en && (phase == PW'(OVERSAMPLE / 2 - 1));

endmodule

// File: rtl/usb_fs_rx_phy.sv
// Full-speed USB receive front end: line decode, SYNC hunt, NRZI decode,
// bit unstuffing, byte assembly and EOP/error detection.
module usb_fs_rx_phy
    import usb_rx_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 4,
    parameter int unsigned STUFF_LEN  = 6,
    parameter int unsigned IDLE_BITS  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_en,
    input  logic       dp_i,
    input  logic       dm_i,
    output logic [1:0] line_state,
    output logic       rx_active,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_eop,
    output logic       rx_error
);

    localparam int unsigned OW = $clog2(STUFF_LEN + 1);
    localparam int unsigned JW = $clog2(IDLE_BITS + 1);
    localparam int unsigned ZW = $clog2(SYNC_MIN_ZEROS + 1);

    line_state_t   ls, ls_raw;
    logic          resync, bit_strobe, dec_one, is_jk;

    rx_state_t     state, state_n;
    line_state_t   prev_jk, prev_jk_n;
    logic [2:0]    sync_cnt, sync_cnt_n;
    logic [ZW-1:0] zeros, zeros_n;
    logic [OW-1:0] ones, ones_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n, data_n;
    logic          residue_err, residue_err_n;
    logic          seen_se0, seen_se0_n;
    logic [JW-1:0] j_cnt, j_cnt_n;
    logic          active_n, valid_n, eop_n, error_n;

    assign ls_raw     = decode_line(dp_i, dm_i);
    assign line_state = ls;
    assign resync     = (ls_raw != ls);
    assign is_jk      = (ls == LS_J) || (ls == LS_K);
    assign dec_one    = (ls == prev_jk);

    always_ff @(posedge clk) begin
        if (rst || !rx_en) begin
            ls <= LS_J;
        end else begin
            ls <= ls_raw;
        end
    end

    usb_rx_dpll #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_dpll (
        .clk       (clk),
        .rst       (rst),
        .en        (rx_en),
        .resync    (resync),
        .bit_strobe(bit_strobe)
    );

    always_comb begin
        state_n       = state;
        prev_jk_n     = prev_jk;
        sync_cnt_n    = sync_cnt;
        zeros_n       = zeros;
        ones_n        = ones;
        bit_cnt_n     = bit_cnt;
        shift_n       = shift;
        data_n        = rx_data;
        residue_err_n = residue_err;
        seen_se0_n    = seen_se0;
        j_cnt_n       = j_cnt;
        active_n      = rx_active;
        valid_n       = 1'b0;
        eop_n         = 1'b0;
        error_n       = 1'b0;

        case (state)
            ST_IDLE: begin
                prev_jk_n = LS_J;
                active_n  = 1'b0;
                if (ls == LS_J && ls_raw == LS_K) begin
                    state_n    = ST_SYNC;
                    sync_cnt_n = '0;
                    zeros_n    = '0;
                end
            end

            ST_SYNC: begin
                if (bit_strobe) begin
                    if (!is_jk) begin
                        state_n = ST_IDLE;
                    end else begin
                        prev_jk_n = ls;
                        if (dec_one && zeros >= ZW'(SYNC_MIN_ZEROS)) begin
                            state_n   = ST_DATA;
                            active_n  = 1'b1;
                            bit_cnt_n = '0;
                            ones_n    = '0;
                        end else begin
                            if (dec_one) begin
                                zeros_n = '0;
                            end else if (zeros != ZW'(SYNC_MIN_ZEROS)) begin
                                zeros_n = zeros + 1'b1;
                            end
                            if (sync_cnt == 3'd7) begin
                                state_n = ST_IDLE;
                            end else begin
                                sync_cnt_n = sync_cnt + 3'd1;
                            end
                        end
                    end
                end
            end

            ST_DATA: begin
                if (bit_strobe) begin
                    case (ls)
                        LS_SE0: begin
                            state_n       = ST_EOP;
                            residue_err_n = (bit_cnt > 3'(DRIBBLE_MAX));
                        end
                        LS_SE1: begin
                            state_n    = ST_ABORT;
                            error_n    = 1'b1;
                            active_n   = 1'b0;
                            seen_se0_n = 1'b0;
                            j_cnt_n    = '0;
                        end
                        default: begin
                            prev_jk_n = ls;
                            // A full run of ones means this bit is the stuffed 0.
                            if (ones == OW'(STUFF_LEN)) begin
                                if (dec_one) begin
                                    state_n    = ST_ABORT;
                                    error_n    = 1'b1;
                                    active_n   = 1'b0;
                                    seen_se0_n = 1'b0;
                                    j_cnt_n    = '0;
                                end else begin
                                    ones_n = '0;
                                end
                            end else begin
                                ones_n    = dec_one ? ones + 1'b1 : '0;
                                shift_n   = {dec_one, shift[7:1]};
                                bit_cnt_n = bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    data_n  = shift_n;
                                    valid_n = 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end

            ST_EOP: begin
                if (bit_strobe) begin
                    case (ls)
                        LS_SE0: ;
                        LS_J: begin
                            state_n  = ST_IDLE;
                            eop_n    = 1'b1;
                            error_n  = residue_err;
                            active_n = 1'b0;
                        end
                        default: begin
                            state_n    = ST_ABORT;
                            error_n    = 1'b1;
                            active_n   = 1'b0;
                            seen_se0_n = 1'b0;
                            j_cnt_n    = '0;
                        end
                    endcase
                end
            end

            ST_ABORT: begin
                active_n = 1'b0;
                if (bit_strobe) begin
                    case (ls)
                        LS_SE0: begin
                            seen_se0_n = 1'b1;
                            j_cnt_n    = '0;
                        end
                        LS_J: begin
                            if (seen_se0 || j_cnt == JW'(IDLE_BITS - 1)) begin
                                state_n = ST_IDLE;
                            end else begin
                                j_cnt_n = j_cnt + 1'b1;
                            end
                        end
                        default: begin
                            seen_se0_n = 1'b0;
                            j_cnt_n    = '0;
                        end
                    endcase
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !rx_en) begin
            state       <= ST_IDLE;
            prev_jk     <= LS_J;
            sync_cnt    <= '0;
            zeros       <= '0;
            ones        <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            residue_err <= 1'b0;
            seen_se0    <= 1'b0;
            j_cnt       <= '0;
            rx_data     <= '0;
            rx_active   <= 1'b0;
            rx_valid    <= 1'b0;
            rx_eop      <= 1'b0;
            rx_error    <= 1'b0;
        end else begin
            state       <= state_n;
            prev_jk     <= prev_jk_n;
            sync_cnt    <= sync_cnt_n;
            zeros       <= zeros_n;
            ones        <= ones_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            residue_err <= residue_err_n;
            seen_se0    <= seen_se0_n;
            j_cnt       <= j_cnt_n;
            rx_data     <= data_n;
            rx_active   <= active_n;
            rx_valid    <= valid_n;
            rx_eop      <= eop_n;
            rx_error    <= error_n;
        end
    end

endmodule

// File: doc/usb_fs_rx_phy.md
Name: usb_fs_rx_phy

Overview:
Full-speed USB receive front end feeding the usbdev packet core inside tt_um_dlmiles_tt04_poc_usbdev.
- Takes pre-synchronized D+/D- samples at OVERSAMPLE× the 12 Mb/s bit rate (48 MHz clk at default).
- Recovers bit timing, detects SYNC, NRZI-decodes, removes stuffed bits and detects EOP.
- Presents a byte stream with valid/active/eop/error strobes to the packet decoder.

Parameters:
OVERSAMPLE, 4, clk cycles per bit; must be ≥4 and even.
STUFF_LEN, 6, consecutive decoded 1s after which a stuffed 0 is mandatory.
IDLE_BITS, 8, J bit-times required to leave ABORT.

Ports:
clk  in  1  sole clock
rst  in  1  synchronous, active-high reset
rx_en  in  1  receiver enable; low forces IDLE
dp_i  in  1  D+ sample, already 2-FF synchronized
dm_i  in  1  D- sample, already 2-FF synchronized
line_state  out  2  registered line state: 0=SE0, 1=J, 2=K, 3=SE1
rx_active  out  1  high from SYNC completion until EOP/abort
rx_valid  out  1  1-cycle strobe; rx_data valid
rx_data  out  8  received byte, LSB-first assembled
rx_eop  out  1  1-cycle strobe at end of packet
rx_error  out  1  1-cycle strobe on stuff, SE1 or framing error

Behaviour:
- Line decode: (dp,dm) = 10 → J, 01 → K, 00 → SE0, 11 → SE1. line_state is registered with 1-cycle latency.
- Reset/rx_en low: state IDLE, phase 0, prev state J, ones count 0. All strobes, rx_active and rx_data are 0. line_state resets to J.
- DPLL: phase counter counts 0..OVERSAMPLE-1 and wraps.
  - Any change of line_state resets the counter to 0.
  - Bit sample is taken when phase == OVERSAMPLE/2-1.
  - Tolerates ±1 clk edge jitter per bit.
- NRZI: decoded bit = 1 if the sampled J/K equals the previous sampled J/K, else 0.
- FSM states: IDLE, SYNC, DATA, EOP, ABORT.
  - IDLE→SYNC: on a J→K line_state transition.
  - SYNC→DATA: after ≥3 decoded 0s, a decoded 1 (KK) arrives. rx_active rises on the cycle of that bit sample. The bit/byte counter clears.
  - SYNC→IDLE: SE0 or SE1 sampled, or 8 bit samples elapse without completion. No strobes are emitted.
  - DATA unstuff: the ones counter increments on decoded 1 and clears on 0.
    - When the counter reaches STUFF_LEN, the next bit is discarded if 0 and the counter clears.
    - If that bit is 1: rx_error pulses, rx_active falls in the same cycle, go to ABORT.
  - DATA assembly: each kept bit shifts into bit 7 of the shift register, LSB first. On the 8th kept bit, rx_data updates and rx_valid pulses on that sample cycle. rx_data holds until the next byte.
  - DATA→EOP: SE0 at a bit sample. Kept bits since the last byte are the residue:
    - residue 0 or 1 (dribble) → discarded silently;
    - residue ≥2 → rx_error pulses together with rx_eop.
  - DATA→ABORT: SE1 at a bit sample → rx_error pulses, rx_active falls.
  - EOP→IDLE: first J bit sample after SE0 → rx_eop pulses 1 cycle and rx_active falls in the same cycle. A K in EOP → rx_error, ABORT.
  - ABORT→IDLE: SE0 followed by J, or IDLE_BITS consecutive J samples. ABORT emits no rx_eop.
- rx_valid and rx_eop never assert in the same cycle. EOP is detected at least one bit-time after the last byte.
- rx_en deassert mid-packet: next cycle IDLE, rx_active falls, no rx_eop, no rx_error.
- The NRZI reference state is the last J/K sample; SE0 does not update it.

Decomposition:
- Package usb_rx_pkg holds:
  - line-state encodings LS_SE0/LS_J/LS_K/LS_SE1;
  - FSM state enum;
  - SYNC_MIN_ZEROS=3 and DRIBBLE_MAX=1 constants.
- Sub-module usb_rx_dpll: phase counter plus bit_strobe output, parameterized by OVERSAMPLE.

Test Plan:
- Reset: assert rst for 3 clk with line at SE0 → all outputs 0, line_state=0 after release; idle J → line_state=1, no strobes.
- Clean packet at 4 clk/bit: SYNC, bytes 0xA5 0x3C, SE0×2 bits, J → two rx_valid pulses with 0xA5 then 0x3C, one rx_eop, rx_active high between SYNC and EOP, no rx_error.
- Stuffing: bytes 0xFF 0xFF with stuffed 0s inserted after every 6 ones → rx_data 0xFF, 0xFF exactly; stuffed bits not counted; rx_eop without error.
- Stuff error: after SYNC send 7 consecutive decoded 1s → rx_error pulse on the 7th bit, rx_active falls, no rx_eop; a following clean packet is received correctly.
- Jitter/framing: the 0xA5 0x3C packet with bit widths alternating 3 and 5 clk → identical bytes. Then a packet ending with 3 residue bits → rx_eop and rx_error in the same cycle.
- rx_en dropped after first byte → rx_active falls the next cycle, no rx_eop; re-enable, and the next packet 0x5A is received with one rx_valid.
